// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply sequencer that borrows the shared ALU while busy
// and passes the datapath's operands straight through to the ALU while idle.
module alu_mul_sequencer #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [1:0]  prod_flags,
  input  logic [31:0] dp_a,
  input  logic [31:0] dp_b,
  input  logic [2:0]  dp_alu_control,
  output logic [31:0] dp_result,
  output logic [3:0]  dp_flags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_LSL = 3'b100,
    ALU_LSR = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_e;

  state_e      state;
  logic [31:0] acc;
  logic [31:0] mc;
  logic [31:0] mp;
  logic [5:0]  iter;
  logic        finish;

  // Z of (mp AND 1) tells CHECK whether the current multiplier bit is clear.
  assign finish = (EARLY_EXIT && (mp == 32'd0)) || (iter == 6'd32);

  // The datapath always sees the ALU, even while the sequencer owns its inputs.
  assign dp_result = alu_result;
  assign dp_flags  = alu_flags;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    alu_a       = dp_a;
    alu_b       = dp_b;
    alu_control = dp_alu_control;
    unique case (state)
      S_CHECK: begin
        alu_a       = mp;
        alu_b       = 32'd1;
        alu_control = ALU_AND;
      end
      S_ADD: begin
        alu_a       = acc;
        alu_b       = mc;
        alu_control = ALU_ADD;
      end
      S_SHL: begin
        alu_a       = mc;
        alu_b       = 32'd1;
        alu_control = ALU_LSL;
      end
      S_SHR: begin
        alu_a       = mp;
        alu_b       = 32'd1;
        alu_control = ALU_LSR;
      end
      S_DONE: begin
        alu_a       = acc;
        alu_b       = 32'd0;
        alu_control = ALU_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      state      <= S_IDLE;
      acc        <= 32'd0;
      mc         <= 32'd0;
      mp         <= 32'd0;
      iter       <= 6'd0;
      product    <= 32'd0;
      prod_flags <= 2'b01;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= 32'd0;
            mc    <= op_a;
            mp    <= op_b;
            iter  <= 6'd0;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (finish) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (alu_flags[2]) begin
            state <= S_SHL;
          end else begin
            state <= S_ADD;
          end
        end
        S_ADD: begin
          acc   <= alu_result;
          state <= S_SHL;
        end
        S_SHL: begin
          mc    <= alu_result;
          state <= S_SHR;
        end
        S_SHR: begin
          mp    <= alu_result;
          iter  <= iter + 6'd1;
          state <= S_CHECK;
        end
        S_DONE: begin
          product    <= acc;
          prod_flags <= {acc[31], acc == 32'd0};
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: one early-exit and one fixed-latency instance,
// each wired to a behavioural ALU, checked against tables and a reference model.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_ee, start_fx;
  logic [31:0] op_a, op_b;
  logic [31:0] dp_a, dp_b;
  logic [2:0]  dp_alu_control;

  logic        busy_ee, done_ee, busy_fx, done_fx;
  logic [31:0] product_ee, product_fx;
  logic [1:0]  prod_flags_ee, prod_flags_fx;
  logic [31:0] dp_result_ee, dp_result_fx;
  logic [3:0]  dp_flags_ee, dp_flags_fx;
  logic [31:0] alu_a_ee, alu_b_ee, alu_a_fx, alu_b_fx;
  logic [2:0]  alu_control_ee, alu_control_fx;
  logic [31:0] alu_result_ee, alu_result_fx;
  logic [3:0]  alu_flags_ee, alu_flags_fx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_prod [2];

  always #5 clk = ~clk;

  // Behavioural ALU: returns {N,Z,C,V, result}.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
    logic [32:0] w;
    logic [31:0] r;
    logic cf, vf;
    cf = 1'b0; vf = 1'b0; r = 32'd0;
    case (c)
      3'b000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cf = w[32];
                    vf = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; cf = w[32];
                    vf = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a << b[4:0];
      3'b101: r = a >> b[4:0];
      default: r = 32'd0;
    endcase
    return {r[31], r == 32'd0, cf, vf, r};
  endfunction

  assign {alu_flags_ee, alu_result_ee} = alu_model(alu_a_ee, alu_b_ee, alu_control_ee);
  assign {alu_flags_fx, alu_result_fx} = alu_model(alu_a_fx, alu_b_fx, alu_control_fx);

  alu_mul_sequencer #(.EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .reset(reset), .start(start_ee), .op_a(op_a), .op_b(op_b),
    .busy(busy_ee), .done(done_ee), .product(product_ee), .prod_flags(prod_flags_ee),
    .dp_a(dp_a), .dp_b(dp_b), .dp_alu_control(dp_alu_control),
    .dp_result(dp_result_ee), .dp_flags(dp_flags_ee),
    .alu_a(alu_a_ee), .alu_b(alu_b_ee), .alu_control(alu_control_ee),
    .alu_result(alu_result_ee), .alu_flags(alu_flags_ee));

  alu_mul_sequencer #(.EARLY_EXIT(1'b0)) u_fx (
    .clk(clk), .reset(reset), .start(start_fx), .op_a(op_a), .op_b(op_b),
    .busy(busy_fx), .done(done_fx), .product(product_fx), .prod_flags(prod_flags_fx),
    .dp_a(dp_a), .dp_b(dp_b), .dp_alu_control(dp_alu_control),
    .dp_result(dp_result_fx), .dp_flags(dp_flags_fx),
    .alu_a(alu_a_fx), .alu_b(alu_b_fx), .alu_control(alu_control_fx),
    .alu_result(alu_result_fx), .alu_flags(alu_flags_fx));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: iterations = bits of the multiplier that get examined.
  function automatic int model_iters(input bit ee, input logic [31:0] b);
    int n;
    n = 32;
    if (ee) begin
      n = 0;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    end
    return n;
  endfunction

  function automatic int model_done(input bit ee, input logic [31:0] b);
    int n, pop;
    n = model_iters(ee, b);
    pop = 0;
    for (int i = 0; i < n; i++) pop += int'(b[i]);
    return 3 * n + pop + 2;
  endfunction

  task automatic run_mul(input bit ee, input logic [31:0] a, input logic [31:0] b,
                         input int exp_done, input logic [31:0] exp_p,
                         input int ign_cyc, input int rst_cyc);
    int cyc, n, errs;
    bit seen, busy_ok;
    logic [2:0] got[$];
    logic [2:0] want[$];
    @(negedge clk);
    op_a = a; op_b = b;
    if (ee) start_ee = 1'b1; else start_fx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_ee = 1'b0; start_fx = 1'b0;
    op_a = ~a; op_b = ~b;
    check("prod_held", ee ? product_ee : product_fx, prev_prod[ee]);
    cyc = 1; seen = 1'b0; busy_ok = 1'b1;
    while (cyc <= 400) begin
      if (!(ee ? busy_ee : busy_fx)) busy_ok = 1'b0;
      if (ee ? done_ee : done_fx) begin seen = 1'b1; break; end
      got.push_back(ee ? alu_control_ee : alu_control_fx);
      if (cyc == rst_cyc) begin
        check("busy_span", 32'(busy_ok), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dp_a = 32'h55; dp_b = 32'h3; dp_alu_control = 3'b011;
        #1;
        check("rst_busy", 32'(ee ? busy_ee : busy_fx), 32'd0);
        check("rst_product", ee ? product_ee : product_fx, 32'd0);
        check("rst_flags", 32'(ee ? prod_flags_ee : prod_flags_fx), 32'd1);
        check("rst_pass_a", ee ? alu_a_ee : alu_a_fx, 32'h55);
        check("rst_pass_ctl", 32'(ee ? alu_control_ee : alu_control_fx), 32'd3);
        check("rst_pass_res", ee ? dp_result_ee : dp_result_fx, 32'h57);
        errs = 0;
        for (int k = 0; k < 20; k++) begin
          if (done_ee || done_fx) errs++;
          @(negedge clk);
        end
        check("rst_no_done", 32'(errs), 32'd0);
        prev_prod[0] = 32'd0; prev_prod[1] = 32'd0;
        return;
      end
      if (cyc == ign_cyc) begin
        op_a = 32'h1; op_b = 32'h1;
        if (ee) start_ee = 1'b1; else start_fx = 1'b1;
      end
      @(negedge clk);
      start_ee = 1'b0; start_fx = 1'b0;
      cyc++;
    end
    check("busy_span", 32'(busy_ok), 32'd1);
    check("done_cycle", seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_done));
    if (!seen) return;
    n = model_iters(ee, b);
    for (int i = 0; i < n; i++) begin
      want.push_back(3'b010);
      if (b[i]) want.push_back(3'b000);
      want.push_back(3'b100);
      want.push_back(3'b101);
    end
    want.push_back(3'b010);
    errs = (got.size() == want.size()) ? 0 : 1;
    if (errs == 0)
      for (int i = 0; i < got.size(); i++) if (got[i] !== want[i]) errs++;
    check("alu_seq", 32'(errs), 32'd0);
    @(negedge clk);
    check("product", ee ? product_ee : product_fx, exp_p);
    check("prod_flags", 32'(ee ? prod_flags_ee : prod_flags_fx),
          32'({exp_p[31], exp_p == 32'd0}));
    check("done_pulse", 32'({ee ? busy_ee : busy_fx, ee ? done_ee : done_fx}), 32'd0);
    prev_prod[ee] = exp_p;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [31:0] res;
  } pass_vec_t;

  typedef struct {
    bit          ee;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          cyc;
    int          ign;
    int          rst;
  } mul_vec_t;

  pass_vec_t pv[6];
  mul_vec_t  mv[10];

  initial begin
    pv[0] = '{32'd10,   32'd1,    3'b100, 32'h14};
    pv[1] = '{32'd10,   32'd1,    3'b101, 32'h5};
    pv[2] = '{32'd7,    32'd5,    3'b000, 32'd12};
    pv[3] = '{32'd7,    32'd5,    3'b001, 32'd2};
    pv[4] = '{32'hF0,   32'h3C,   3'b010, 32'h30};
    pv[5] = '{32'hF0,   32'h0F,   3'b010, 32'h0};

    mv[0] = '{1'b1, 32'd3,          32'd5,          32'hF,          13,  0, 0};
    mv[1] = '{1'b1, 32'h1234_5678,  32'd0,          32'd0,          2,   0, 0};
    mv[2] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          130, 0, 0};
    mv[3] = '{1'b0, 32'hDEAD_BEEF,  32'd1,          32'hDEAD_BEEF,  99,  0, 0};
    mv[4] = '{1'b1, 32'h0001_0000,  32'h0001_0000,  32'd0,          54,  5, 0};
    mv[5] = '{1'b1, 32'd0,          32'h8000_0001,  32'd0,          100, 0, 0};
    mv[6] = '{1'b1, 32'h8000_0000,  32'd3,          32'h8000_0000,  10,  0, 0};
    mv[7] = '{1'b0, 32'h1234_5678,  32'd0,          32'd0,          98,  0, 0};
    mv[8] = '{1'b1, 32'd3,          32'd5,          32'hF,          13,  0, 6};
    mv[9] = '{1'b1, 32'd7,          32'd6,          32'h2A,         13,  0, 0};

    reset = 1'b1; start_ee = 1'b0; start_fx = 1'b0;
    op_a = '0; op_b = '0; dp_a = '0; dp_b = '0; dp_alu_control = '0;
    prev_prod[0] = 32'd0; prev_prod[1] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'({busy_ee, busy_fx}), 32'd0);
    check("reset_done", 32'({done_ee, done_fx}), 32'd0);
    check("reset_product", product_ee | product_fx, 32'd0);
    check("reset_flags", 32'({prod_flags_ee, prod_flags_fx}), 32'b0101);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dp_a = pv[i].a; dp_b = pv[i].b; dp_alu_control = pv[i].ctl;
      #1;
      check("pass_a", alu_a_ee, pv[i].a);
      check("pass_b", alu_b_fx, pv[i].b);
      check("pass_ctl", 32'(alu_control_ee), 32'(pv[i].ctl));
      check("pass_res_ee", dp_result_ee, pv[i].res);
      check("pass_res_fx", dp_result_fx, pv[i].res);
      check("pass_z", 32'(dp_flags_ee[2]), 32'(pv[i].res == 32'd0));
    end

    for (int i = 0; i < 10; i++)
      run_mul(mv[i].ee, mv[i].a, mv[i].b, mv[i].cyc, mv[i].p, mv[i].ign, mv[i].rst);

    for (int i = 0; i < 24; i++) begin
      bit ee;
      logic [31:0] a, b;
      ee = (i % 2) == 0;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 7 == 3) b = 32'd0;
      run_mul(ee, a, b, model_done(ee, b), a * b, 3, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
